// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the pipeline registers
// Used by the ID/EX, EX/MEM and MEM/WB registers.
package pipeline_pkg;

  localparam int PIPE_XLEN         = 64;
  localparam int ALU_CONTROL_WIDTH = 4;

  // ALU operation encodings; ADD is deliberately non-zero, so a bubble is not all-zero
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_OP_AND = 4'b0000;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_OP_OR  = 4'b0001;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_OP_ADD = 4'b0010;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_OP_SUB = 4'b0110;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_OP_SLT = 4'b0111;

  typedef struct packed {
    logic                         reg_write;
    logic [1:0]                   result_src;  // 00 ALU, 01 memory, 10 PC+4
    logic                         mem_write;
    logic                         jump;
    logic                         branch;
    logic                         alu_src;     // 0 rs2, 1 immediate
    logic [ALU_CONTROL_WIDTH-1:0] alu_control;
    logic [2:0]                   funct3;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic [PIPE_XLEN-1:0] rd1;
    logic [PIPE_XLEN-1:0] rd2;
    logic [PIPE_XLEN-1:0] pc;
    logic [PIPE_XLEN-1:0] pc_plus4;
    logic [PIPE_XLEN-1:0] imm_ext;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
  } id_ex_data_t;

  // Bubble: no architectural side effects, ALU idles on ADD
  localparam id_ex_ctrl_t ID_EX_CTRL_BUBBLE = '{
    reg_write:   1'b0,
    result_src:  2'b00,
    mem_write:   1'b0,
    jump:        1'b0,
    branch:      1'b0,
    alu_src:     1'b0,
    alu_control: ALU_OP_ADD,
    funct3:      3'b000
  };

endpackage

// File: rtl/pipe_reg_en_clr.sv
// rtl/pipe_reg_en_clr.sv - pipeline register with enable and synchronous clear
// Ports: clk, rst (sync, active-high), en (load), clr (load CLR_VALUE), d, q.
// Priority: rst > clr > en; rst and clr both load CLR_VALUE.
module pipe_reg_en_clr #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= CLR_VALUE;
    end else if (clr) begin
      q <= CLR_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_register.sv
// rtl/id_ex_register.sv - Decode-to-Execute pipeline register with bubble counter
// Ports: clk, rst (sync, active-high); stall_e_i holds, flush_e_i loads a bubble;
// *_d_i decode control/data in, *_e_o registered copies out, valid_e_o,
// bubble_count_o saturating count of cycles with valid_e_o low.
module id_ex_register
  import pipeline_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall_e_i,
  input  logic                         flush_e_i,
  input  logic                         valid_d_i,
  input  logic                         reg_write_d_i,
  input  logic [1:0]                   result_src_d_i,
  input  logic                         mem_write_d_i,
  input  logic                         jump_d_i,
  input  logic                         branch_d_i,
  input  logic                         alu_src_d_i,
  input  logic [ALU_CONTROL_WIDTH-1:0] alu_control_d_i,
  input  logic [2:0]                   funct3_d_i,
  input  logic [XLEN-1:0]              rd1_d_i,
  input  logic [XLEN-1:0]              rd2_d_i,
  input  logic [XLEN-1:0]              pc_d_i,
  input  logic [XLEN-1:0]              pc_plus4_d_i,
  input  logic [XLEN-1:0]              imm_ext_d_i,
  input  logic [4:0]                   rs1_d_i,
  input  logic [4:0]                   rs2_d_i,
  input  logic [4:0]                   rd_d_i,
  output logic                         valid_e_o,
  output logic                         reg_write_e_o,
  output logic [1:0]                   result_src_e_o,
  output logic                         mem_write_e_o,
  output logic                         jump_e_o,
  output logic                         branch_e_o,
  output logic                         alu_src_e_o,
  output logic [ALU_CONTROL_WIDTH-1:0] alu_control_e_o,
  output logic [2:0]                   funct3_e_o,
  output logic [XLEN-1:0]              rd1_e_o,
  output logic [XLEN-1:0]              rd2_e_o,
  output logic [XLEN-1:0]              pc_e_o,
  output logic [XLEN-1:0]              pc_plus4_e_o,
  output logic [XLEN-1:0]              imm_ext_e_o,
  output logic [4:0]                   rs1_e_o,
  output logic [4:0]                   rs2_e_o,
  output logic [4:0]                   rd_e_o,
  output logic [CNT_WIDTH-1:0]         bubble_count_o
);

  id_ex_ctrl_t          ctrl_d, ctrl_e;
  id_ex_data_t          data_d, data_e;
  logic                 valid_q;
  logic [CNT_WIDTH-1:0] bubble_cnt_q;

  // A non-valid slot must never write state or redirect fetch, whatever decode says
  assign ctrl_d = '{
    reg_write:   reg_write_d_i & valid_d_i,
    result_src:  result_src_d_i,
    mem_write:   mem_write_d_i & valid_d_i,
    jump:        jump_d_i & valid_d_i,
    branch:      branch_d_i & valid_d_i,
    alu_src:     alu_src_d_i,
    alu_control: alu_control_d_i,
    funct3:      funct3_d_i
  };

  assign data_d = '{
    rd1:      rd1_d_i,
    rd2:      rd2_d_i,
    pc:       pc_d_i,
    pc_plus4: pc_plus4_d_i,
    imm_ext:  imm_ext_d_i,
    rs1:      rs1_d_i,
    rs2:      rs2_d_i,
    rd:       rd_d_i
  };

  pipe_reg_en_clr #(
    .WIDTH     ($bits(id_ex_ctrl_t)),
    .CLR_VALUE (ID_EX_CTRL_BUBBLE)
  ) u_ctrl_reg (
    .clk (clk),
    .rst (rst),
    .en  (~stall_e_i),
    .clr (flush_e_i),
    .d   (ctrl_d),
    .q   (ctrl_e)
  );

  pipe_reg_en_clr #(
    .WIDTH     ($bits(id_ex_data_t)),
    .CLR_VALUE ('0)
  ) u_data_reg (
    .clk (clk),
    .rst (rst),
    .en  (~stall_e_i),
    .clr (flush_e_i),
    .d   (data_d),
    .q   (data_e)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (flush_e_i) begin
      valid_q <= 1'b0;
    end else if (!stall_e_i) begin
      valid_q <= valid_d_i;
    end
  end

  // Counts cycles Execute spends on a bubble, stalled or not; sticks at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else if (!valid_q && (bubble_cnt_q != {CNT_WIDTH{1'b1}})) begin
      bubble_cnt_q <= bubble_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign valid_e_o       = valid_q;
  assign reg_write_e_o   = ctrl_e.reg_write;
  assign result_src_e_o  = ctrl_e.result_src;
  assign mem_write_e_o   = ctrl_e.mem_write;
  assign jump_e_o        = ctrl_e.jump;
  assign branch_e_o      = ctrl_e.branch;
  assign alu_src_e_o     = ctrl_e.alu_src;
  assign alu_control_e_o = ctrl_e.alu_control;
  assign funct3_e_o      = ctrl_e.funct3;
  assign rd1_e_o         = data_e.rd1;
  assign rd2_e_o         = data_e.rd2;
  assign pc_e_o          = data_e.pc;
  assign pc_plus4_e_o    = data_e.pc_plus4;
  assign imm_ext_e_o     = data_e.imm_ext;
  assign rs1_e_o         = data_e.rs1;
  assign rs2_e_o         = data_e.rs2;
  assign rd_e_o          = data_e.rd;
  assign bubble_count_o  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_register.sv
// tb/tb_id_ex_register.sv - self-checking bench for id_ex_register
module tb_id_ex_register;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush;
  logic        valid_d, reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
  logic [1:0]  result_src_d;
  logic [3:0]  alu_control_d;
  logic [2:0]  funct3_d;
  logic [63:0] rd1_d, rd2_d, pc_d, pc4_d, imm_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;

  logic        valid_e, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e;
  logic [1:0]  result_src_e;
  logic [3:0]  alu_control_e;
  logic [2:0]  funct3_e;
  logic [63:0] rd1_e, rd2_e, pc_e, pc4_e, imm_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [CNT_W-1:0] bubble_count;

  id_ex_register #(.XLEN(64), .CNT_WIDTH(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall_e_i(stall), .flush_e_i(flush),
    .valid_d_i(valid_d), .reg_write_d_i(reg_write_d), .result_src_d_i(result_src_d),
    .mem_write_d_i(mem_write_d), .jump_d_i(jump_d), .branch_d_i(branch_d),
    .alu_src_d_i(alu_src_d), .alu_control_d_i(alu_control_d), .funct3_d_i(funct3_d),
    .rd1_d_i(rd1_d), .rd2_d_i(rd2_d), .pc_d_i(pc_d), .pc_plus4_d_i(pc4_d),
    .imm_ext_d_i(imm_d), .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .rd_d_i(rd_d),
    .valid_e_o(valid_e), .reg_write_e_o(reg_write_e), .result_src_e_o(result_src_e),
    .mem_write_e_o(mem_write_e), .jump_e_o(jump_e), .branch_e_o(branch_e),
    .alu_src_e_o(alu_src_e), .alu_control_e_o(alu_control_e), .funct3_e_o(funct3_e),
    .rd1_e_o(rd1_e), .rd2_e_o(rd2_e), .pc_e_o(pc_e), .pc_plus4_e_o(pc4_e),
    .imm_ext_e_o(imm_e), .rs1_e_o(rs1_e), .rs2_e_o(rs2_e), .rd_e_o(rd_e),
    .bubble_count_o(bubble_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what Execute should be holding, as plain fields
  typedef struct {
    logic        valid, reg_write, mem_write, jump, branch, alu_src;
    logic [1:0]  result_src;
    logic [3:0]  alu_control;
    logic [2:0]  funct3;
    logic [63:0] rd1, rd2, pc, pc4, imm;
    logic [4:0]  rs1, rs2, rd;
  } stage_t;

  stage_t m;
  int     m_cnt   = 0;
  bit     model_ok = 1'b0;

  function automatic stage_t bubble();
    stage_t s;
    s.valid = 0; s.reg_write = 0; s.mem_write = 0; s.jump = 0; s.branch = 0;
    s.alu_src = 0; s.result_src = 2'b00; s.alu_control = 4'b0010; s.funct3 = 3'b000;
    s.rd1 = 0; s.rd2 = 0; s.pc = 0; s.pc4 = 0; s.imm = 0;
    s.rs1 = 0; s.rs2 = 0; s.rd = 0;
    return s;
  endfunction

  function automatic stage_t capture();
    stage_t s;
    s.valid      = valid_d;
    s.reg_write  = valid_d ? reg_write_d : 1'b0;
    s.mem_write  = valid_d ? mem_write_d : 1'b0;
    s.jump       = valid_d ? jump_d : 1'b0;
    s.branch     = valid_d ? branch_d : 1'b0;
    s.alu_src    = alu_src_d;
    s.result_src = result_src_d;
    s.alu_control = alu_control_d;
    s.funct3     = funct3_d;
    s.rd1 = rd1_d; s.rd2 = rd2_d; s.pc = pc_d; s.pc4 = pc4_d; s.imm = imm_d;
    s.rs1 = rs1_d; s.rs2 = rs2_d; s.rd = rd_d;
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m = bubble();
      m_cnt = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (!m.valid && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (flush)       m = bubble();
      else if (!stall) m = capture();
    end
  end

  always @(posedge clk) begin
    #1;
    if (model_ok) begin
      chk("ctrl_vs_model",
          512'({valid_e, reg_write_e, result_src_e, mem_write_e, jump_e, branch_e,
                alu_src_e, alu_control_e, funct3_e}),
          512'({m.valid, m.reg_write, m.result_src, m.mem_write, m.jump, m.branch,
                m.alu_src, m.alu_control, m.funct3}));
      chk("data_vs_model",
          512'({rd1_e, rd2_e, pc_e, pc4_e, imm_e, rs1_e, rs2_e, rd_e}),
          512'({m.rd1, m.rd2, m.pc, m.pc4, m.imm, m.rs1, m.rs2, m.rd}));
      chk("count_vs_model", 512'(bubble_count), 512'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_d = 0; reg_write_d = 0; mem_write_d = 0; jump_d = 0; branch_d = 0;
    alu_src_d = 0; result_src_d = 0; alu_control_d = 4'b0010; funct3_d = 0;
    rd1_d = 0; rd2_d = 0; pc_d = 0; pc4_d = 0; imm_d = 0;
    rs1_d = 0; rs2_d = 0; rd_d = 0;
  endtask

  task automatic rand_inputs();
    valid_d = 1'($urandom); reg_write_d = 1'($urandom); mem_write_d = 1'($urandom);
    jump_d = 1'($urandom); branch_d = 1'($urandom); alu_src_d = 1'($urandom);
    result_src_d = 2'($urandom_range(0, 2)); alu_control_d = 4'($urandom);
    funct3_d = 3'($urandom);
    rd1_d = {$urandom, $urandom}; rd2_d = {$urandom, $urandom};
    pc_d = {$urandom, $urandom}; pc4_d = pc_d + 64'd4; imm_d = {$urandom, $urandom};
    rs1_d = 5'($urandom); rs2_d = 5'($urandom); rd_d = 5'($urandom);
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0;
    idle_inputs();

    // Reset
    step(); step();
    chk("reset_count", 512'(bubble_count), 512'(0));
    chk("reset_valid", 512'(valid_e), 512'(0));
    chk("reset_alu_add", 512'(alu_control_e), 512'(4'b0010));

    // ADDI x3, x1, 5
    rst = 0;
    valid_d = 1; reg_write_d = 1; alu_src_d = 1; imm_d = 64'd5; rd_d = 5'd3; rs1_d = 5'd1;
    pc_d = 64'h100; pc4_d = 64'h104;
    step();
    chk("addi_valid", 512'(valid_e), 512'(1));
    chk("addi_reg_write", 512'(reg_write_e), 512'(1));
    chk("addi_imm", 512'(imm_e), 512'(5));
    chk("addi_rd", 512'(rd_e), 512'(3));
    chk("addi_count", 512'(bubble_count), 512'(1));

    // SW x5, 8(x2), then a 3-cycle stall with a different instruction waiting
    idle_inputs();
    valid_d = 1; mem_write_d = 1; alu_src_d = 1; funct3_d = 3'b010; imm_d = 64'd8;
    rs1_d = 5'd2; rs2_d = 5'd5;
    step();
    chk("sw_mem_write", 512'(mem_write_e), 512'(1));
    idle_inputs();
    valid_d = 1; reg_write_d = 1; alu_src_d = 1; imm_d = 64'd77; rd_d = 5'd9;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_mem_write", 512'(mem_write_e), 512'(1));
      chk("stall_imm", 512'(imm_e), 512'(8));
    end
    stall = 0;
    step();
    chk("post_stall_imm", 512'(imm_e), 512'(77));
    chk("post_stall_mem_write", 512'(mem_write_e), 512'(0));

    // BEQ, then flush together with stall
    idle_inputs();
    valid_d = 1; branch_d = 1; rs1_d = 5'd4; rs2_d = 5'd5; imm_d = -64'sd16;
    alu_control_d = 4'b0110; rd_d = 5'd7;
    step();
    chk("beq_branch", 512'(branch_e), 512'(1));
    flush = 1; stall = 1;
    step();
    chk("flush_branch", 512'(branch_e), 512'(0));
    chk("flush_valid", 512'(valid_e), 512'(0));
    chk("flush_rd", 512'(rd_e), 512'(0));
    chk("flush_alu_add", 512'(alu_control_e), 512'(4'b0010));
    chk("flush_count", 512'(bubble_count), 512'(1));

    // Invalid slot with side-effect bits set
    flush = 0; stall = 0;
    idle_inputs();
    valid_d = 0; reg_write_d = 1; mem_write_d = 1; jump_d = 1; rd1_d = 64'hDEAD;
    step();
    chk("bubble_count_incr", 512'(bubble_count), 512'(2));
    chk("invalid_reg_write", 512'(reg_write_e), 512'(0));
    chk("invalid_mem_write", 512'(mem_write_e), 512'(0));
    chk("invalid_rd1", 512'(rd1_e), 512'(64'hDEAD));

    // 20 flushes: counter climbs to 15 and sticks
    flush = 1;
    for (int i = 0; i < 20; i++) step();
    chk("sat_count", 512'(bubble_count), 512'(15));
    rst = 1;
    step();
    chk("rst_clears_count", 512'(bubble_count), 512'(0));
    rst = 0; flush = 0;

    // Randomized traffic; flush density varies by epoch to reach saturation too
    for (int epoch = 0; epoch < 12; epoch++) begin
      int flush_pct;
      flush_pct = (epoch % 3 == 2) ? 90 : 10;
      for (int i = 0; i < 250; i++) begin
        rand_inputs();
        rst   = ($urandom_range(0, 99) < 2);
        flush = ($urandom_range(0, 99) < flush_pct);
        stall = ($urandom_range(0, 99) < 25);
        step();
      end
    end

    rst = 0; flush = 0; stall = 0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
